fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core, directly upstream of the ID-stage decoder. It owns the program counter and issues word-aligned requests to instruction memory. Returned instructions are buffered together with their PC, then presented to the decoder over a valid/ready handshake. Branch/jump redirects from the branch unit flush all younger work and restart fetch at the target.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, issues word-aligned imem requests and
// buffers returned instructions with their PC for the ID stage.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]      pc;
    logic [31:0]      redirect_tgt;

    logic [31:0]      trk_addr [DEPTH];
    logic [DEPTH-1:0] trk_stale;
    logic [PW-1:0]    trk_wr;
    logic [PW-1:0]    trk_rd;
    logic [CW-1:0]    trk_cnt;

    logic [31:0]      q_instr [DEPTH];
    logic [31:0]      q_pc    [DEPTH];
    logic [PW-1:0]    q_wr;
    logic [PW-1:0]    q_rd;
    logic [CW-1:0]    q_cnt;

    logic [CW:0]      used;
    logic             credit_ok;
    logic             accept;
    logic             rsp_fire;
    logic             q_push;
    logic             consume;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    // Tracker plus queue never exceed DEPTH, so a response always has a queue slot.
    assign used      = {1'b0, trk_cnt} + {1'b0, q_cnt};
    assign credit_ok = used < (CW+1)'(DEPTH);

    assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc;

    assign accept   = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (trk_cnt != '0);
    assign q_push   = rsp_fire && !trk_stale[trk_rd] && !redirect_valid;

    assign id_valid = (q_cnt != '0);
    assign consume  = id_valid && id_ready;
    assign id_instr = id_valid ? q_instr[q_rd] : NOP;
    assign id_pc    = id_valid ? q_pc[q_rd]    : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_tgt;
        end else if (accept) begin
            pc <= pc + 32'd4;
        end
    end

    // In-flight tracker: entries outstanding across a redirect are marked stale
    // so their responses are dropped on arrival.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_wr    <= '0;
            trk_rd    <= '0;
            trk_cnt   <= '0;
            trk_stale <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                trk_addr[i] <= '0;
            end
        end else begin
            if (accept) begin
                trk_addr[trk_wr] <= pc;
                trk_wr           <= trk_wr + 1'b1;
            end
            if (rsp_fire) begin
                trk_rd <= trk_rd + 1'b1;
            end
            if (redirect_valid) begin
                trk_stale <= '1;
            end else if (accept) begin
                trk_stale[trk_wr] <= 1'b0;
            end
            case ({accept, rsp_fire})
                2'b10:   trk_cnt <= trk_cnt + 1'b1;
                2'b01:   trk_cnt <= trk_cnt - 1'b1;
                default: trk_cnt <= trk_cnt;
            endcase
        end
    end

    // Instruction queue; a redirect empties it regardless of same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else begin
            if (q_push) begin
                q_instr[q_wr] <= imem_rsp_data;
                q_pc[q_wr]    <= trk_addr[trk_rd];
                q_wr          <= q_wr + 1'b1;
            end
            if (consume) begin
                q_rd <= q_rd + 1'b1;
            end
            case ({q_push, consume})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a transaction-level model tracks the
// fetch PC, outstanding memory requests (tagged with a redirect epoch) and the
// instructions owed to ID.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_pc;
        int          epoch;
        int          due;
    } mem_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } id_t;

    mem_t        mem_q[$];
    id_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    logic [31:0] model_pc = RESET_PC;

    bit          s_valid = 1'b0;
    bit          s_accept, s_rsp, s_redir;
    logic [31:0] s_addr, s_rtgt;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_instr, prev_pc;
    int          first_req_cyc = -1;
    int          first_id_cyc = -1;

    int          p_idr = 100, p_reqr = 100, p_redir = 0, min_lat = 1, max_lat = 1;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc = 32'h0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_1003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples just before each rising edge.
    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            s_valid    = 1'b0;
            prev_stall = 1'b0;
            chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
            chk("rst_req_addr", imem_req_addr, RESET_PC);
            chk("rst_id_valid", 32'(id_valid), 32'h0);
            chk("rst_id_instr", id_instr, 32'h0000_0013);
            chk("rst_id_pc", id_pc, 32'h0);
        end else begin
            chk("req_valid", 32'(imem_req_valid),
                32'(!redirect_valid && (mem_q.size() + exp_q.size() < DEPTH)));
            if (imem_req_valid) chk("req_addr", imem_req_addr, model_pc);
            chk("id_valid", 32'(id_valid), 32'(exp_q.size() != 0));
            if (id_valid) begin
                if (first_id_cyc < 0) first_id_cyc = cyc;
                if (prev_stall) begin
                    chk("stall_instr", id_instr, prev_instr);
                    chk("stall_pc", id_pc, prev_pc);
                end
                if (id_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL id_handshake: got pc %h, expected no instruction", id_pc);
                    end else begin
                        id_t e;
                        checks--;
                        e = exp_q.pop_front();
                        chk("id_instr", id_instr, e.instr);
                        chk("id_pc", id_pc, e.pc);
                    end
                end
            end else begin
                chk("idle_instr", id_instr, 32'h0000_0013);
                chk("idle_pc", id_pc, 32'h0);
            end
            if (imem_req_valid && imem_req_ready && first_req_cyc < 0) first_req_cyc = cyc;
            prev_stall = id_valid && !id_ready;
            prev_instr = id_instr;
            prev_pc    = id_pc;
            s_accept   = imem_req_valid && imem_req_ready;
            s_addr     = imem_req_addr;
            s_rsp      = imem_rsp_valid;
            s_redir    = redirect_valid;
            s_rtgt     = redirect_pc;
            s_valid    = 1'b1;
        end
    end

    // Reference model update, just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (s_valid && rst_n) begin
            if (s_rsp && mem_q.size() > 0) begin
                mem_t m;
                m = mem_q.pop_front();
                if (m.epoch == epoch && !s_redir)
                    exp_q.push_back('{instr: mem_data(m.exp_pc), pc: m.exp_pc});
            end
            if (s_redir) begin
                exp_q.delete();
                epoch++;
                model_pc = s_rtgt & 32'hFFFF_FFFC;
            end else if (s_accept) begin
                mem_q.push_back('{addr: s_addr, exp_pc: model_pc, epoch: epoch,
                                  due: cyc + int'($urandom_range(max_lat, min_lat))});
                model_pc = model_pc + 32'd4;
            end
        end
        s_valid = 1'b0;
        cyc++;
    end

    task automatic drive();
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else begin
            redirect_valid = ($urandom_range(99, 0) < p_redir);
            case ($urandom_range(3, 0))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = $urandom_range(1023, 0);
                2:       redirect_pc = 32'hFFFF_FFFC;
                default: redirect_pc = 32'hFFFF_FFF8 | $urandom_range(3, 0);
            endcase
        end
        id_ready       = ($urandom_range(99, 0) < p_idr);
        imem_req_ready = ($urandom_range(99, 0) < p_reqr);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            drive();
        end
    endtask

    task automatic set_idle();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        set_idle();
        mem_q.delete();
        exp_q.delete();
        model_pc = RESET_PC;
        epoch++;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] tgt, input int settle);
        force_pc    = tgt;
        force_redir = 1'b1;
        run(settle);
    endtask

    initial begin
        set_idle();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Streaming with single-cycle memory.
        run(20);
        chk("first_id_latency", 32'(first_id_cyc - first_req_cyc), 32'd2);

        // ID backpressure, then release.
        p_idr = 0;
        run(8);
        p_idr = 100;
        run(10);

        // Redirect with requests outstanding in a 3-cycle memory.
        min_lat = 3; max_lat = 3;
        run(4);
        redirect_to(32'h0000_0100, 14);

        // Misaligned target and PC wrap.
        min_lat = 1; max_lat = 1;
        redirect_to(32'h0000_0203, 8);
        redirect_to(32'hFFFF_FFFC, 8);

        // Memory refuses requests for a while.
        p_reqr = 0;
        run(5);
        p_reqr = 100;
        run(5);

        // Randomized mix of stalls, latencies and redirects.
        p_idr = 70; p_reqr = 70; p_redir = 5; max_lat = 4;
        run(3000);

        // Asynchronous reset mid-stream.
        do_reset();
        run(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
